// File: rtl/openhmc_rf_master_pkg.sv
// Shared types for the openHMC register-file master.
// Holds the access FSM state encoding used by the RTL and its debug port.
package openhmc_rf_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rf_m_state_e;

endpackage

// File: rtl/openhmc_rf_master_if.sv
// Request/response and RF-port bundle for openhmc_rf_master.
// Handshakes: a transfer happens on any rising clk_hmc edge where valid && ready;
// valid never waits on ready, and payload stays stable while valid is high and ready is low.
interface openhmc_rf_master_if #(
  parameter int HMC_RF_AWIDTH = 4,
  parameter int HMC_RF_WWIDTH = 64,
  parameter int HMC_RF_RWIDTH = 64
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [HMC_RF_AWIDTH-1:0] req_addr;
  logic [HMC_RF_WWIDTH-1:0] req_wdata;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [HMC_RF_RWIDTH-1:0] rsp_rdata;
  logic                     rsp_invalid;
  logic                     rsp_timeout;

  logic [HMC_RF_AWIDTH-1:0] rf_address;
  logic                     rf_read_en;
  logic                     rf_write_en;
  logic [HMC_RF_WWIDTH-1:0] rf_write_data;
  logic [HMC_RF_RWIDTH-1:0] rf_read_data;
  logic                     rf_invalid_address;
  logic                     rf_access_complete;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout,
    input  rsp_ready,
    output rf_address, rf_read_en, rf_write_en, rf_write_data,
    input  rf_read_data, rf_invalid_address, rf_access_complete
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout,
    output rsp_ready,
    input  rf_address, rf_read_en, rf_write_en, rf_write_data,
    output rf_read_data, rf_invalid_address, rf_access_complete
  );

endinterface

// File: rtl/openhmc_rf_master.sv
// Single-outstanding register-file initiator: one request in, one RF strobe out,
// wait for completion or timeout, then hold the response until it is consumed.
module openhmc_rf_master
  import openhmc_rf_master_pkg::*;
#(
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk_hmc,
  input  logic                 res_n_hmc,
  openhmc_rf_master_if.master  bus,
  output logic                 stray_complete,
  output rf_m_state_e          state_dbg
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rf_m_state_e              state_q, state_d;
  logic                     op_write_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [HMC_RF_AWIDTH-1:0] addr_q;
  logic [HMC_RF_WWIDTH-1:0] wdata_q;
  logic [HMC_RF_RWIDTH-1:0] rdata_q;
  logic                     invalid_q;
  logic                     timeout_q;
  logic                     stray_q;
  logic                     timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      // A completion landing on the last counted cycle still wins over the timeout.
      WAIT:    if (bus.rf_access_complete || timeout_hit) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) begin
      op_write_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      invalid_q  <= 1'b0;
      timeout_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      stray_q <= bus.rf_access_complete && (state_q != WAIT);
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_write_q <= bus.req_write;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          if (bus.rf_access_complete) begin
            rdata_q   <= (!op_write_q && !bus.rf_invalid_address) ? bus.rf_read_data : '0;
            invalid_q <= bus.rf_invalid_address;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            invalid_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            // Stops at CNT_LAST because that value always leaves WAIT.
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q   <= '0;
            invalid_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and handshake flags decode from state so reset removes them at once.
  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rf_read_en    = (state_q == ISSUE) && !op_write_q;
  assign bus.rf_write_en   = (state_q == ISSUE) &&  op_write_q;
  assign bus.rf_address    = addr_q;
  assign bus.rf_write_data = wdata_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_invalid   = invalid_q;
  assign bus.rsp_timeout   = timeout_q;
  assign stray_complete    = stray_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_openhmc_rf_master.sv
// Directed plus randomized bench for openhmc_rf_master with an expected-response queue
// computed from the access rules (completion delay, invalid flag, timeout limit).
module tb_openhmc_rf_master;
  import openhmc_rf_master_pkg::*;

  localparam int AW = 4;
  localparam int WW = 64;
  localparam int RW = 64;
  localparam int TO = 8;

  logic        clk_hmc = 1'b0;
  logic        res_n_hmc;
  logic        stray_complete;
  rf_m_state_e state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  // Expected response: {rdata, invalid, timeout}
  logic [RW+1:0] exp_q[$];

  // Clock and reset
  always #5 clk_hmc = ~clk_hmc;

  openhmc_rf_master_if #(.HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW)) bus ();

  openhmc_rf_master #(
    .HMC_RF_AWIDTH (AW),
    .HMC_RF_WWIDTH (WW),
    .HMC_RF_RWIDTH (RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_hmc       (clk_hmc),
    .res_n_hmc     (res_n_hmc),
    .bus           (bus),
    .stray_complete(stray_complete),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a completion within TO wait cycles answers; otherwise a timeout.
  function automatic logic [RW+1:0] ref_rsp(input logic wr, input int k, input logic inv,
                                            input logic [RW-1:0] d);
    if (k < 1 || k > TO) return {{RW{1'b0}}, 1'b0, 1'b1};
    return {((!wr && !inv) ? d : {RW{1'b0}}), inv, 1'b0};
  endfunction

  task automatic cycle();
    @(posedge clk_hmc);
    @(negedge clk_hmc);
  endtask

  task automatic check_idle_quiet(input string tag);
    check(tag, {bus.req_ready, bus.rsp_valid, bus.rf_read_en, bus.rf_write_en,
                bus.rsp_invalid, bus.rsp_timeout, stray_complete}, 128'b1000000);
  endtask

  // Driver: one full access. k = WAIT cycle carrying the completion (0 = never),
  // bp = cycles of response backpressure, stray = inject a completion while in RESP.
  task automatic do_access(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] wd,
                           input int k, input logic inv, input logic [RW-1:0] d,
                           input int bp, input logic stray);
    logic [RW+1:0] e;
    int n;
    n = (k >= 1 && k <= TO) ? k : TO;
    exp_q.push_back(ref_rsp(wr, k, inv, d));
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    cycle();
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = {$urandom, $urandom};
    check("strobe", {bus.rf_write_en, bus.rf_read_en, bus.req_ready, bus.rsp_valid},
          {wr, !wr, 2'b00});
    check("issue_bus", {bus.rf_address, bus.rf_write_data}, {a, wd});
    for (int j = 1; j <= n; j++) begin
      cycle();
      check("wait_quiet", {bus.rf_write_en, bus.rf_read_en, bus.rsp_valid, bus.req_ready}, 0);
      check("wait_hold", {bus.rf_address, bus.rf_write_data}, {a, wd});
      if (j == k) begin
        bus.rf_access_complete = 1'b1;
        bus.rf_invalid_address = inv;
        bus.rf_read_data       = d;
      end
    end
    cycle();
    bus.rf_access_complete = 1'b0;
    bus.rf_invalid_address = 1'($urandom);
    bus.rf_read_data       = {$urandom, $urandom};
    check("rsp_valid", {bus.rsp_valid, bus.req_ready}, 2'b10);
    e = exp_q.pop_front();
    check("rsp_fields", {bus.rsp_rdata, bus.rsp_invalid, bus.rsp_timeout}, e);
    for (int j = 0; j < bp; j++) begin
      cycle();
      check("stray_resp", stray_complete, stray && (j == 1));
      bus.rf_access_complete = stray && (j == 0);
      check("bp_stable", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_invalid,
                          bus.rsp_timeout}, {2'b10, e});
    end
    bus.rf_access_complete = 1'b0;
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    check("rsp_cleared", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_invalid,
                          bus.rsp_timeout, bus.rf_address}, {2'b01, {(RW + 2){1'b0}}, a});
  endtask

  initial begin
    res_n_hmc              = 1'b0;
    bus.req_valid          = 1'b0;
    bus.req_write          = 1'b0;
    bus.req_addr           = '0;
    bus.req_wdata          = '0;
    bus.rsp_ready          = 1'b0;
    bus.rf_read_data       = '0;
    bus.rf_invalid_address = 1'b0;
    bus.rf_access_complete = 1'b0;
    repeat (3) @(negedge clk_hmc);
    check_idle_quiet("reset_flags");
    check("reset_bus", {bus.rf_address, bus.rf_write_data, bus.rsp_rdata}, 0);
    check("reset_state", state_dbg, IDLE);
    res_n_hmc = 1'b1;
    cycle();

    // Write with completion two cycles after the strobe
    do_access(1'b1, 4'h3, 64'hDEAD_BEEF, 2, 1'b0, {$urandom, $urandom}, 0, 1'b0);
    // Read answered on the first WAIT cycle, issued back-to-back
    do_access(1'b0, 4'h5, {$urandom, $urandom}, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    // Read that times out, then a late completion three cycles after the response
    do_access(1'b0, 4'h7, {$urandom, $urandom}, 0, 1'b0, {$urandom, $urandom}, 0, 1'b0);
    cycle();
    cycle();
    bus.rf_access_complete = 1'b1;
    cycle();
    bus.rf_access_complete = 1'b0;
    check("stray_idle", {stray_complete, bus.req_ready, bus.rsp_valid}, 3'b110);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check_idle_quiet("no_second_rsp");
    end
    // Completion on the very last counted cycle beats the timeout
    do_access(1'b0, 4'h1, {$urandom, $urandom}, TO, 1'b0, 64'hFACE_0000_CAFE_0001, 0, 1'b0);
    // Invalid address
    do_access(1'b0, 4'h9, {$urandom, $urandom}, 3, 1'b1, 64'h5555_AAAA_5555_AAAA, 0, 1'b0);
    // Ten cycles of backpressure with a stray completion in RESP, then back-to-back write
    do_access(1'b0, 4'h2, {$urandom, $urandom}, 4, 1'b0, {$urandom, $urandom}, 10, 1'b1);
    do_access(1'b1, 4'hC, {$urandom, $urandom}, 1, 1'b0, {$urandom, $urandom}, 0, 1'b0);

    // Reset during WAIT
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'hA;
    bus.req_wdata = 64'h1111_2222_3333_4444;
    cycle();
    bus.req_valid = 1'b0;
    cycle();
    cycle();
    res_n_hmc = 1'b0;
    #1;
    check_idle_quiet("reset_mid_flags");
    check("reset_mid_bus", {bus.rf_address, bus.rf_write_data, bus.rsp_rdata}, 0);
    @(negedge clk_hmc);
    res_n_hmc = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check_idle_quiet("reset_no_rsp");
    end
    do_access(1'b0, 4'hA, {$urandom, $urandom}, 2, 1'b0, {$urandom, $urandom}, 1, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 16; i++) begin
      logic wr;
      int   k;
      int   bp;
      wr = 1'($urandom);
      k  = $urandom_range(0, TO);
      bp = $urandom_range(0, 3);
      do_access(wr, AW'($urandom), {$urandom, $urandom}, k, ($urandom_range(0, 3) == 0),
                {$urandom, $urandom}, bp, (bp >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/openhmc_rf_master.md
Name: openhmc_rf_master

Overview:
- Host-side initiator for the openHMC register file. Turns one-at-a-time request/response handshakes into RF accesses on rf_address, rf_read_en, rf_write_en and rf_write_data.
- Waits for rf_access_complete, or times out, then returns the read data and status.
- By construction it never asserts read and write enables together, and it holds address and write data stable for the whole access.
- Sits between a control or debug bus adapter and openhmc_top's RF port, in the clk_hmc domain.

Parameters:
- HMC_RF_AWIDTH, 4, RF address width.
- HMC_RF_WWIDTH, 64, RF write data width.
- HMC_RF_RWIDTH, 64, RF read data width.
- TIMEOUT_CYCLES, 256, WAIT cycles before an access is aborted. Must be >=2.

Ports:
- clk_hmc  in  1  clock.
- res_n_hmc  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1=write, 0=read.
- req_addr  in  HMC_RF_AWIDTH  register address.
- req_wdata  in  HMC_RF_WWIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  HMC_RF_RWIDTH  read data; 0 for writes, timeouts and invalid addresses.
- rsp_invalid  out  1  RF flagged rf_invalid_address.
- rsp_timeout  out  1  access aborted by timeout.
- rf_address  out  HMC_RF_AWIDTH  to RF.
- rf_read_en  out  1  one-cycle read strobe.
- rf_write_en  out  1  one-cycle write strobe.
- rf_write_data  out  HMC_RF_WWIDTH  to RF.
- rf_read_data  in  HMC_RF_RWIDTH  from RF.
- rf_invalid_address  in  1  from RF, valid with rf_access_complete.
- rf_access_complete  in  1  from RF, one-cycle pulse.
- stray_complete  out  1  one-cycle pulse: rf_access_complete seen outside WAIT.

Behaviour:
- Clock and reset: clk_hmc is the only clock. res_n_hmc is asynchronous, active-low, and all flops reset on it.
- Reset values:
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - rf_address, rf_write_data and rsp_rdata = 0.
- Reset mid-access: the access is dropped, no response is produced, and the RF enables drop immediately.
- FSM states are IDLE, ISSUE, WAIT, RESP. Outputs are registered or decoded from state only, so there is no combinational req->rf path.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_write, req_addr and req_wdata into rf_address, rf_write_data and the op flag, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rf_read_en=!op or rf_write_en=op, never both.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Enables are 0. rf_address and rf_write_data are held unchanged.
  - Counter increments each cycle.
  - On rf_access_complete: capture rf_read_data (reads only, when rf_invalid_address=0) into rsp_rdata, capture rf_invalid_address into rsp_invalid, then go to RESP.
  - Otherwise, when counter==TIMEOUT_CYCLES-1: rsp_timeout=1, rsp_rdata=0, go to RESP.
  - A complete arriving in the same cycle as the timeout takes precedence; there is no timeout in that case.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, clear rsp_*, go to IDLE.
  - rf_address is kept until the next request.
- Latency:
  - Request accepted at cycle N, strobe at N+1.
  - With complete at N+1+k (k>=1), rsp_valid rises at N+2+k.
  - Minimum request-to-response is 3 cycles.
  - Throughput is at most one access per 4 cycles.
- stray_complete pulses when rf_access_complete=1 in IDLE, ISSUE or RESP, including a late complete after a timeout. In those states the pulse is otherwise ignored and no state changes.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and never wraps.

Decomposition:
- Package openhmc_rf_master_pkg holds the state enum rf_m_state_e {IDLE, ISSUE, WAIT, RESP}.
- No sub-module is needed. The single FSM plus counter fits in roughly 150-200 lines.

Test Plan:
- Write addr=4'h3, wdata=64'hDEAD_BEEF, complete 2 cycles after strobe:
  - rf_write_en high exactly 1 cycle, rf_read_en=0 throughout.
  - rf_address and rf_write_data stable until complete.
  - rsp_valid with rsp_invalid=0, rsp_timeout=0, rsp_rdata=0.
- Read addr=4'h5, RF returns 64'h0123_4567_89AB_CDEF with complete 1 cycle after strobe:
  - rsp_valid 3 cycles after acceptance, rsp_rdata equal to that value.
- Read with no complete, TIMEOUT_CYCLES=8:
  - rsp_timeout=1 exactly 8 WAIT cycles after the strobe, rsp_rdata=0.
  - A complete injected 3 cycles later gives a stray_complete pulse and no second response.
- Read with rf_invalid_address=1 at complete: rsp_invalid=1, rsp_rdata=0.
- Backpressure:
  - rsp_ready held low 10 cycles: rsp_* stable and req_ready=0 throughout.
  - A back-to-back second request is accepted the cycle after the rsp handshake.
- res_n_hmc pulsed low during WAIT:
  - All outputs return to reset values immediately, no response is produced.
  - The next request completes normally.
